// File: rtl/spi_mst_pkg.sv
// Shared definitions for the SPI master: FSM state encodings, default frame
// geometry, and the frame layout constants used by host-side software.
package spi_mst_pkg;

  // Default frame length (bits) and sck half-period (clk cycles)
  localparam int unsigned SIZE_DEF = 72;
  localparam int unsigned DIV_DEF  = 4;

  // Transfer FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Frame layout: tag pattern in the top bits, byte-aligned field offsets
  localparam int unsigned TAG_W       = 6;
  localparam logic [5:0]  FRAME_TAG   = 6'b101010;
  localparam int unsigned TAG_LSB     = 66;
  localparam int unsigned FLD_OFF_0   = 0;
  localparam int unsigned FLD_OFF_8   = 8;
  localparam int unsigned FLD_OFF_16  = 16;
  localparam int unsigned FLD_OFF_24  = 24;
  localparam int unsigned FLD_HI_LSB  = 64;
  localparam int unsigned FLD_HI_MSB  = 67;

endpackage

// File: rtl/spi_mst_div.sv
// Phase tick generator: counts 0..div-1 and wraps, flagging the last and
// next-to-last cycle of every sck half-period.
//   clk, rst   : clock, synchronous active-high reset
//   restart    : hold the counter at phase 0
//   last_c     : current cycle is the last of the phase
//   pre_c      : current cycle is the one before the last
module spi_div #(
  parameter int unsigned div = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic last_c,
  output logic pre_c
);

  localparam int unsigned PW = $clog2(div);

  logic [PW-1:0] cnt;

  assign last_c = (cnt == PW'(div - 1));
  assign pre_c  = (cnt == PW'(div - 2));

  // Phase counter, wrapping at the end of each half-period
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (last_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/spi_mst.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one frame of `size` bits
// per slave-select assertion.
//   clk, rst : clock, synchronous active-high reset
//   stb, pdi : start pulse and parallel frame to send (sampled at acceptance)
//   pdo, rdy : last received frame and its one-cycle completion pulse
//   bsy      : transfer in progress
//   sck, sdo, sdi, n_scs : serial bus
module spi_mst
  import spi_mst_pkg::*;
#(
  parameter int unsigned size = SIZE_DEF,
  parameter int unsigned div  = DIV_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stb,
  input  logic [size-1:0] pdi,
  output logic [size-1:0] pdo,
  output logic            bsy,
  output logic            rdy,
  output logic            sck,
  output logic            sdo,
  input  logic            sdi,
  output logic            n_scs
);

  localparam int unsigned BW = $clog2(size + 1);

  state_t          state;
  logic [size-1:0] tx;
  logic [size-1:0] rx;
  logic [BW-1:0]   bit_cnt;
  logic            last_c;
  logic            pre_c;

  // Phase timing restarts from zero at frame acceptance
  spi_div #(.div(div)) u_div (
    .clk     (clk),
    .rst     (rst),
    .restart (state == IDLE),
    .last_c  (last_c),
    .pre_c   (pre_c)
  );

  // Transfer FSM with registered bus and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sck     <= 1'b0;
      n_scs   <= 1'b1;
      sdo     <= 1'b0;
      bsy     <= 1'b0;
      rdy     <= 1'b0;
      pdo     <= '0;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (stb) begin
            tx      <= pdi;
            sdo     <= pdi[size-1];
            n_scs   <= 1'b0;
            bsy     <= 1'b1;
            bit_cnt <= BW'(size);
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (last_c) begin
            sck   <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          // Sample at the end of the high phase; advance sdo as sck falls
          if (last_c) begin
            rx      <= {rx[size-2:0], sdi};
            tx      <= {tx[size-2:0], 1'b0};
            sdo     <= tx[size-2];
            bit_cnt <= bit_cnt - BW'(1);
            sck     <= 1'b0;
            state   <= LOW;
          end
        end
        LOW: begin
          if (last_c) begin
            if (bit_cnt == '0) begin
              n_scs <= 1'b1;
              sdo   <= 1'b0;
              state <= GAP;
            end else begin
              sck   <= 1'b1;
              state <= HIGH;
            end
          end
        end
        GAP: begin
          // Registered rdy/pdo are set one cycle early so they appear in
          // the last GAP cycle
          if (pre_c) begin
            pdo <= rx;
            rdy <= 1'b1;
          end
          if (last_c) begin
            bsy   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mst.sv
// Self-checking bench for spi_mst: 72-bit/div 4 frames in loopback and
// against a mode-0 slave model, ignored stb, mid-frame reset, and 8-bit/div 2
// back-to-back frames.
module tb_spi_mst;

  localparam logic [71:0] SLV = 72'hAB_00000001_00000002;

  typedef struct {
    logic [71:0] pdi;
    logic        slave;
    logic        extra;
    logic [71:0] exp_pdo;
    logic [71:0] exp_srx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        stb72 = 1'b0;
  logic [71:0] pdi72 = '0;
  logic [71:0] pdo72;
  logic        bsy72, rdy72, sck72, sdo72, sdi72, n_scs72;

  logic        stb8 = 1'b0;
  logic [7:0]  pdi8 = '0;
  logic [7:0]  pdo8;
  logic        bsy8, rdy8, sck8, sdo8, n_scs8;

  logic        use_slave = 1'b0;
  logic [71:0] sl_sh = '0;
  logic [71:0] sl_rx = '0;
  logic        sck_q = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int run8 = 0;
  int last_run8 = 0;

  always #5 clk = ~clk;

  spi_mst #(.size(72), .div(4)) u72 (
    .clk(clk), .rst(rst), .stb(stb72), .pdi(pdi72), .pdo(pdo72),
    .bsy(bsy72), .rdy(rdy72), .sck(sck72), .sdo(sdo72), .sdi(sdi72),
    .n_scs(n_scs72)
  );

  spi_mst #(.size(8), .div(2)) u8 (
    .clk(clk), .rst(rst), .stb(stb8), .pdi(pdi8), .pdo(pdo8),
    .bsy(bsy8), .rdy(rdy8), .sck(sck8), .sdo(sdo8), .sdi(sdo8),
    .n_scs(n_scs8)
  );

  assign sdi72 = use_slave ? sl_sh[71] : sdo72;

  // Mode-0 slave: present MSB while selected, shift out after sck falls,
  // capture master data on sck rising
  always @(posedge clk) begin
    sck_q <= sck72;
    if (n_scs72) sl_sh <= SLV;
    else if (sck_q && !sck72) sl_sh <= {sl_sh[70:0], 1'b0};
    if (!sck_q && sck72) sl_rx <= {sl_rx[70:0], sdo72};
  end

  // Length of the most recent completed n_scs-high run on the 8-bit master
  always @(posedge clk) begin
    if (n_scs8) run8 = run8 + 1;
    else begin
      if (run8 != 0) last_run8 = run8;
      run8 = 0;
    end
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run72(input vec_t v);
    int   n, nb, nrdy, rises, idle_bad;
    logic sck_p;
    use_slave = v.slave;
    @(negedge clk);
    pdi72 = v.pdi; stb72 = 1'b1;
    n = 0; nb = 0; nrdy = 0; rises = 0; idle_bad = 0; sck_p = 1'b0;
    while (nrdy == 0 && n < 2000) begin
      @(negedge clk);
      stb72 = 1'b0;
      n++;
      if (v.extra && (n == 1 || n == 10 || n == 500)) begin
        stb72 = 1'b1; pdi72 = '0;
      end
      if (bsy72) nb++;
      if (sck72 && !sck_p) rises++;
      sck_p = sck72;
      if (n_scs72 && (sdo72 || sck72)) idle_bad++;
      if (rdy72) nrdy++;
    end
    chk("rdy_latency", 72'(n), 72'd584);
    chk("sck_rises", 72'(rises), 72'd72);
    chk("pdo", pdo72, v.exp_pdo);
    if (v.slave) chk("slave_rx", sl_rx, v.exp_srx);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      stb72 = 1'b0;
      if (rdy72) nrdy++;
      if (bsy72) nb++;
      if (n_scs72 && (sdo72 || sck72)) idle_bad++;
    end
    chk("bsy_cycles", 72'(nb), 72'd584);
    chk("rdy_pulses", 72'(nrdy), 72'd1);
    chk("idle_bus", 72'(idle_bad), 72'd0);
    chk("pdo_hold", pdo72, v.exp_pdo);
  endtask

  vec_t vt[5];

  initial begin
    int n, nb;

    vt[0] = '{72'hA5_0123456789ABCDEF, 1'b0, 1'b0, 72'hA5_0123456789ABCDEF, 72'h0};
    vt[1] = '{72'h5A_FEDCBA9876543210, 1'b1, 1'b0, SLV, 72'h5A_FEDCBA9876543210};
    vt[2] = '{72'hFF_FFFFFFFFFFFFFFFF, 1'b0, 1'b0, 72'hFF_FFFFFFFFFFFFFFFF, 72'h0};
    vt[3] = '{72'h80_0000000000000001, 1'b0, 1'b1, 72'h80_0000000000000001, 72'h0};
    vt[4] = '{72'h00_0000000000000000, 1'b1, 1'b0, SLV, 72'h0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_n_scs", 72'(n_scs72), 72'd1);
    chk("rst_sck", 72'(sck72), 72'd0);
    chk("rst_sdo", 72'(sdo72), 72'd0);
    chk("rst_bsy", 72'(bsy72), 72'd0);
    chk("rst_rdy", 72'(rdy72), 72'd0);
    chk("rst_pdo", pdo72, 72'd0);

    for (int i = 0; i < 5; i++) run72(vt[i]);

    // Mid-frame reset with a coincident stb
    use_slave = 1'b0;
    @(negedge clk);
    pdi72 = 72'h3C_0F0F0F0F0F0F0F0F; stb72 = 1'b1;
    @(negedge clk);
    stb72 = 1'b0;
    repeat (199) @(negedge clk);
    chk("pre_rst_bsy", 72'(bsy72), 72'd1);
    rst = 1'b1; stb72 = 1'b1;
    @(negedge clk);
    rst = 1'b0; stb72 = 1'b0;
    chk("abort_n_scs", 72'(n_scs72), 72'd1);
    chk("abort_sck", 72'(sck72), 72'd0);
    chk("abort_bsy", 72'(bsy72), 72'd0);
    chk("abort_rdy", 72'(rdy72), 72'd0);
    chk("abort_pdo", pdo72, 72'd0);
    repeat (4) @(negedge clk);
    chk("rst_stb_dropped", 72'(bsy72), 72'd0);
    run72(vt[0]);

    // 8-bit back-to-back frames
    @(negedge clk);
    pdi8 = 8'hC3; stb8 = 1'b1;
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      stb8 = 1'b0; n++;
      if (bsy8) nb++;
    end while (!rdy8 && n < 500);
    chk("b2b_bsy_a", 72'(nb), 72'd36);
    chk("b2b_pdo_a", 72'(pdo8), 72'hC3);
    @(negedge clk);
    chk("b2b_idle_bsy", 72'(bsy8), 72'd0);
    pdi8 = 8'h5A; stb8 = 1'b1;
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      stb8 = 1'b0; n++;
      if (bsy8) nb++;
    end while (!rdy8 && n < 500);
    chk("b2b_bsy_b", 72'(nb), 72'd36);
    chk("b2b_pdo_b", 72'(pdo8), 72'h5A);
    chk("b2b_gap", 72'(last_run8), 72'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_mst.md
SPI_MST -- requirements
Module: spi_mst

Interface
REQ-001 Parameter `size`, default 72: frame length in bits, legal range >= 2.
REQ-002 Parameter `div`, default 4: sck half-period in clk cycles, legal range >= 2.
REQ-003 Port `clk`, input, 1: single system clock; all logic samples on its rising edge.
REQ-004 Port `rst`, input, 1: reset, synchronous, active-high.
REQ-005 Port `stb`, input, 1: start request, one-cycle pulse.
REQ-006 Port `pdi`, input, size: parallel frame to transmit, MSB first.
REQ-007 Port `pdo`, output, size: last received frame, registered.
REQ-008 Port `bsy`, output, 1: transfer in progress.
REQ-009 Port `rdy`, output, 1: one-cycle pulse on frame completion.
REQ-010 Port `sck`, output, 1: serial clock to the slave; idles low.
REQ-011 Port `sdo`, output, 1: serial data to the slave's sdi.
REQ-012 Port `sdi`, input, 1: serial data from the slave's sdo.
REQ-013 Port `n_scs`, output, 1: slave select, active-low; idles high.

Function
REQ-014 The block SHALL implement the SPI master matching the counter's slave: mode 0 (CPOL=0, CPHA=0), MSB first, one frame of `size` bits per n_scs assertion.
REQ-015 States SHALL be IDLE, SETUP, HIGH, LOW, GAP; the reset state SHALL be IDLE.
REQ-016 In IDLE, stb=1 SHALL latch pdi into the shift register, drive n_scs=0 and sdo=pdi[size-1] from the next cycle, set bsy=1, and enter SETUP.
REQ-017 SETUP SHALL last `div` cycles with sck=0, then enter HIGH.
REQ-018 HIGH SHALL hold sck=1 for `div` cycles; in its last cycle the block SHALL shift sdi into the LSB of the receive register.
REQ-019 LOW SHALL hold sck=0 for `div` cycles; on entry to LOW, sdo SHALL advance to the next transmit bit.
REQ-020 After the LOW phase of bit 0 (the `size`-th bit), the block SHALL drive n_scs=1 and enter GAP; otherwise it SHALL return to HIGH.
REQ-021 GAP SHALL last `div` cycles with n_scs=1 and sck=0; in its last cycle the block SHALL load pdo from the receive register, pulse rdy=1, and return to IDLE.
REQ-022 bsy SHALL be 1 from the cycle after accepted stb through the GAP cycle that asserts rdy, inclusive: exactly div*(2*size+2) cycles.
REQ-023 A back-to-back stb in the cycle after rdy SHALL be accepted; the minimum n_scs-high time between frames SHALL be div+1 cycles.
REQ-024 stb while bsy=1 SHALL be ignored; pdi SHALL be sampled only at acceptance.
REQ-025 pdo SHALL change only at rdy and SHALL hold its value otherwise.
REQ-026 sdo SHALL equal the current transmit MSB while n_scs=0, and 0 while n_scs=1.
REQ-027 The phase counter SHALL be clog2(div) bits wide and the bit counter clog2(size+1) bits wide; neither SHALL wrap during a frame.

Reset
REQ-028 While rst=1, on the next clk edge: state=IDLE, sck=0, n_scs=1, sdo=0, bsy=0, rdy=0, pdo=0, and all counters and shift registers cleared.
REQ-029 rst asserted mid-frame SHALL abort the frame with no rdy pulse, and n_scs SHALL go high on the following edge.
REQ-030 An stb coincident with rst=1 SHALL be discarded.

Structure
REQ-031 The shared header SHALL hold the state encodings and the default `size`/`div` values; the frame layout constants (frame tag bits 101010, field offsets 0/8/16/24/64-67) SHALL live there too, for host-side use.
REQ-032 The block SHALL have one natural sub-module, `spi_div`: a `div`-cycle phase tick generator with a synchronous restart input.

Verification
REQ-033 Loopback (sdi tied to sdo), size=72, div=4, pdi=72'hA5_0123456789ABCDEF -> rdy after 584 cycles, pdo equal to pdi.
REQ-034 A bench slave model returning 72'hAB_00000001_00000002 (pattern 101010, eac=1, bac=1, cnx=1, cnr=2) -> pdo identical; slave sdi bits match pdi MSB-first on sck rising edges.
REQ-035 stb pulsed at cycles 1, 10 and 500 of a 584-cycle frame -> exactly one frame on the bus and one rdy pulse.
REQ-036 rst asserted at cycle 200 of a frame -> n_scs=1, sck=0 and bsy=0 the next cycle, no rdy, pdo=0; a new stb then completes normally.
REQ-037 size=8, div=2, stb re-asserted in the cycle after rdy -> two frames of 36 bsy cycles each, separated by 3 cycles of n_scs=1.
